// File: rtl/vmas_pkg.sv
// Shared definitions for the VMA selector / burst sequencer: source encodings,
// FSM state type and default widths.
package vmas_pkg;

    localparam int VW_DEF      = 32;
    localparam int LCW_DEF     = 26;
    localparam int MAPI_LO_DEF = 8;
    localparam int MAPI_HI_DEF = 23;
    localparam int CNTW_DEF    = 4;
    localparam int STRIDE_DEF  = 1;

    typedef enum logic [1:0] {
        VMASEL_LC  = 2'd0,
        VMASEL_OB  = 2'd1,
        VMASEL_MD  = 2'd2,
        VMASEL_INC = 2'd3
    } vmasel_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_e;

endpackage

// File: rtl/vmas_seq_if.sv
// Map-stage handshake: registered map input field with valid/ready.
// The sequencer drives the master side, the map stage the slave side.
interface vmas_seq_if
    import vmas_pkg::*;
#(
    parameter int MAPW = MAPI_HI_DEF - MAPI_LO_DEF + 1
) ();

    logic [MAPW-1:0] mapi;
    logic            map_valid;
    logic            map_ready;

    modport master (output mapi, output map_valid, input map_ready);
    modport slave  (input mapi, input map_valid, output map_ready);

endinterface

// File: rtl/vmas_src_mux.sv
// Combinational VMA source select: word-addressed LC, OB, MD or VMA+STRIDE.
// Also exports the incremented VMA for the burst engine.
module vmas_src_mux
    import vmas_pkg::*;
#(
    parameter int VW     = VW_DEF,
    parameter int LCW    = LCW_DEF,
    parameter int STRIDE = STRIDE_DEF
) (
    input  logic [1:0]     vmasel,
    input  logic [VW-1:0]  ob,
    input  logic [VW-1:0]  md,
    input  logic [LCW-1:0] lc,
    input  logic [VW-1:0]  vma,
    output logic [VW-1:0]  src,
    output logic [VW-1:0]  inc
);

    // LC is a byte address; the two low bits never reach the VMA.
    logic [1:0] lc_byte_unused;
    assign lc_byte_unused = lc[1:0];

    always_comb begin
        inc = vma + VW'(STRIDE);
        src = '0;
        case (vmasel)
            VMASEL_LC:  src = VW'(lc[LCW-1:2]);
            VMASEL_OB:  src = ob;
            VMASEL_MD:  src = md;
            VMASEL_INC: src = inc;
            default:    src = '0;
        endcase
    end

endmodule

// File: rtl/vmas_seq.sv
// VMA register with sequential-access burst engine feeding the map stage.
// Optional build macro VMAS_PAGE_CROSS_EN: flag page crossings and insert a map-reload cycle.
module vmas_seq
    import vmas_pkg::*;
#(
    parameter int VW      = VW_DEF,
    parameter int LCW     = LCW_DEF,
    parameter int MAPI_LO = MAPI_LO_DEF,
    parameter int MAPI_HI = MAPI_HI_DEF,
    parameter int CNTW    = CNTW_DEF,
    parameter int STRIDE  = STRIDE_DEF
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [VW-1:0]    ob,
    input  logic [VW-1:0]    md,
    input  logic [LCW-1:0]   lc,
    input  logic [1:0]       vmasel,
    input  logic             vma_we,
    input  logic             burst_start,
    input  logic [CNTW-1:0]  burst_len,
    input  logic             memprepare,
    vmas_seq_if.master       map,
    output logic [VW-1:0]    vma,
    output logic             busy,
    output logic             burst_done,
    output logic             page_cross
);

    localparam int MAPW = MAPI_HI - MAPI_LO + 1;

    state_e          state_reg, state_next;
    logic [VW-1:0]   vma_reg, vma_next;
    logic [MAPW-1:0] mapi_reg, mapi_next;
    logic            valid_reg, valid_next;
    logic            busy_reg, busy_next;
    logic            done_reg, done_next;
    logic            pc_reg, pc_next;
    logic            hold_reg, hold_next;
    logic [CNTW-1:0] cnt_reg, cnt_next;

    logic [VW-1:0]   src;
    logic [VW-1:0]   vma_inc;
    logic            cross_now;
    logic            handshake;

    vmas_src_mux #(
        .VW     (VW),
        .LCW    (LCW),
        .STRIDE (STRIDE)
    ) u_src_mux (
        .vmasel (vmasel),
        .ob     (ob),
        .md     (md),
        .lc     (lc),
        .vma    (vma_reg),
        .src    (src),
        .inc    (vma_inc)
    );

`ifdef VMAS_PAGE_CROSS_EN
    // Any change at or above the map field means the map RAM must reload.
    assign cross_now = |(vma_reg[VW-1:MAPI_LO] ^ vma_inc[VW-1:MAPI_LO]);
`else
    assign cross_now = 1'b0;
`endif

    assign handshake = valid_reg & map.map_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= ST_IDLE;
            vma_reg   <= '0;
            mapi_reg  <= '0;
            valid_reg <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            pc_reg    <= 1'b0;
            hold_reg  <= 1'b0;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            vma_reg   <= vma_next;
            mapi_reg  <= mapi_next;
            valid_reg <= valid_next;
            busy_reg  <= busy_next;
            done_reg  <= done_next;
            pc_reg    <= pc_next;
            hold_reg  <= hold_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        vma_next   = vma_reg;
        mapi_next  = mapi_reg;
        valid_next = valid_reg;
        busy_next  = busy_reg;
        done_next  = 1'b0;
        pc_next    = pc_reg;
        hold_next  = 1'b0;
        cnt_next   = cnt_reg;

        case (state_reg)
            ST_IDLE: begin
                if (burst_start || vma_we) begin
                    vma_next   = src;
                    mapi_next  = memprepare ? src[MAPI_HI:MAPI_LO] : md[MAPI_HI:MAPI_LO];
                    valid_next = 1'b1;
                    pc_next    = 1'b0;
                    state_next = ST_WAIT;
                    // Burst wins over a simultaneous single load; length 0 acts as 1.
                    if (burst_start) begin
                        cnt_next  = (burst_len == '0) ? '0 : burst_len - CNTW'(1);
                        busy_next = 1'b1;
                    end else begin
                        cnt_next  = '0;
                        busy_next = 1'b0;
                    end
                end
            end

            ST_ISSUE: begin
                vma_next   = vma_inc;
                mapi_next  = vma_inc[MAPI_HI:MAPI_LO];
                cnt_next   = cnt_reg - CNTW'(1);
                state_next = ST_WAIT;
                if (cross_now) begin
                    valid_next = 1'b0;
                    hold_next  = 1'b1;
                    pc_next    = 1'b1;
                end else begin
                    valid_next = 1'b1;
                end
            end

            ST_WAIT: begin
                if (hold_reg) begin
                    valid_next = 1'b1;
                end else if (handshake) begin
                    valid_next = 1'b0;
                    pc_next    = 1'b0;
                    if (cnt_reg == '0) begin
                        done_next  = busy_reg;
                        busy_next  = 1'b0;
                        state_next = ST_IDLE;
                    end else begin
                        state_next = ST_ISSUE;
                    end
                end
            end

            default: begin
                state_next = ST_IDLE;
                valid_next = 1'b0;
                busy_next  = 1'b0;
            end
        endcase
    end

    assign vma           = vma_reg;
    assign busy          = busy_reg;
    assign burst_done    = done_reg;
    assign page_cross    = pc_reg;
    assign map.mapi      = mapi_reg;
    assign map.map_valid = valid_reg;

endmodule

// File: tb/tb_vmas_seq.sv
// Directed self-checking bench for vmas_seq: single loads, bursts, backpressure,
// wrap/page-cross and mid-burst reset.
module tb_vmas_seq;

`ifdef VMAS_PAGE_CROSS_EN
    localparam bit PC_EN = 1'b1;
`else
    localparam bit PC_EN = 1'b0;
`endif

    logic        clk;
    logic        reset_n;
    logic [31:0] ob, md;
    logic [25:0] lc;
    logic [1:0]  vmasel;
    logic        vma_we, burst_start, memprepare;
    logic [3:0]  burst_len;
    logic [31:0] vma;
    logic        busy, burst_done, page_cross;

    int n_cmp = 0;
    int n_err = 0;

    vmas_seq_if #(.MAPW(16)) mif ();

    vmas_seq dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .ob          (ob),
        .md          (md),
        .lc          (lc),
        .vmasel      (vmasel),
        .vma_we      (vma_we),
        .burst_start (burst_start),
        .burst_len   (burst_len),
        .memprepare  (memprepare),
        .map         (mif.master),
        .vma         (vma),
        .busy        (busy),
        .burst_done  (burst_done),
        .page_cross  (page_cross)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b1; ob = '0; md = '0; lc = '0; vmasel = '0;
        vma_we = 0; burst_start = 0; burst_len = '0; memprepare = 0; mif.map_ready = 0;
        #2 reset_n = 1'b0;
        #1;
        n_cmp++; if (vma !== 32'h0) begin n_err++; $display("FAIL rst_vma: got %h expected %h", vma, 32'h0); end
        n_cmp++; if (mif.mapi !== 16'h0) begin n_err++; $display("FAIL rst_mapi: got %h expected %h", mif.mapi, 16'h0); end
        n_cmp++; if (mif.map_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b expected 0", mif.map_valid); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b expected 0", busy); end
        n_cmp++; if (burst_done !== 1'b0) begin n_err++; $display("FAIL rst_done: got %b expected 0", burst_done); end
        n_cmp++; if (page_cross !== 1'b0) begin n_err++; $display("FAIL rst_pc: got %b expected 0", page_cross); end
        repeat (3) tick();
        reset_n = 1'b1;
        tick();
        $display("reset: vma=%h mapi=%h valid=%b", vma, mif.mapi, mif.map_valid);
    endtask

    task automatic test_lc_load();
        vmasel = 2'd0; lc = 26'h0000404; memprepare = 1; vma_we = 1;
        tick();
        vma_we = 0;
        $display("lc load: vma=%h mapi=%h valid=%b", vma, mif.mapi, mif.map_valid);
        n_cmp++; if (vma !== 32'h101) begin n_err++; $display("FAIL lc_vma: got %h expected %h", vma, 32'h101); end
        n_cmp++; if (mif.mapi !== 16'h0001) begin n_err++; $display("FAIL lc_mapi: got %h expected %h", mif.mapi, 16'h0001); end
        n_cmp++; if (mif.map_valid !== 1'b1) begin n_err++; $display("FAIL lc_valid: got %b expected 1", mif.map_valid); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL lc_busy: got %b expected 0", busy); end
        mif.map_ready = 1;
        tick();
        mif.map_ready = 0;
        n_cmp++; if (mif.map_valid !== 1'b0) begin n_err++; $display("FAIL lc_accept_valid: got %b expected 0", mif.map_valid); end
        n_cmp++; if (burst_done !== 1'b0) begin n_err++; $display("FAIL lc_no_done: got %b expected 0", burst_done); end
    endtask

    task automatic test_md_map();
        vmasel = 2'd1; ob = 32'h00ABCD00; md = 32'h00123400; memprepare = 0; vma_we = 1;
        tick();
        vma_we = 0;
        $display("md map: vma=%h mapi=%h valid=%b", vma, mif.mapi, mif.map_valid);
        n_cmp++; if (vma !== 32'h00ABCD00) begin n_err++; $display("FAIL md_vma: got %h expected %h", vma, 32'h00ABCD00); end
        n_cmp++; if (mif.mapi !== 16'h1234) begin n_err++; $display("FAIL md_mapi: got %h expected %h", mif.mapi, 16'h1234); end
        mif.map_ready = 1;
        tick();
        mif.map_ready = 0;
        n_cmp++; if (mif.map_valid !== 1'b0) begin n_err++; $display("FAIL md_accept_valid: got %b expected 0", mif.map_valid); end
    endtask

    task automatic test_burst3();
        int acc = 0;
        int done_cnt = 0;
        int done_at = -1;
        vmasel = 2'd1; ob = 32'h10; burst_len = 4'd3; memprepare = 1; mif.map_ready = 1; burst_start = 1;
        tick();
        burst_start = 0;
        for (int c = 0; c < 16; c++) begin
            if (burst_done) begin
                done_cnt++;
                done_at = acc;
                n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL b3_busy_fall: got %b expected 0", busy); end
            end
            if (mif.map_valid) begin
                $display("burst3 word %0d: vma=%h mapi=%h cycle=%0d", acc, vma, mif.mapi, c);
                n_cmp++; if (vma !== 32'h10 + 32'(acc)) begin n_err++; $display("FAIL b3_vma: got %h expected %h", vma, 32'h10 + 32'(acc)); end
                n_cmp++; if (c !== 2 * acc) begin n_err++; $display("FAIL b3_timing: got cycle %0d expected %0d", c, 2 * acc); end
                n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL b3_busy: got %b expected 1", busy); end
                acc++;
            end
            tick();
        end
        mif.map_ready = 0;
        n_cmp++; if (acc !== 3) begin n_err++; $display("FAIL b3_words: got %0d expected 3", acc); end
        n_cmp++; if (done_cnt !== 1) begin n_err++; $display("FAIL b3_done_cnt: got %0d expected 1", done_cnt); end
        n_cmp++; if (done_at !== 3) begin n_err++; $display("FAIL b3_done_at: got %0d expected 3", done_at); end
    endtask

    task automatic test_backpressure();
        vmasel = 2'd1; ob = 32'h00012320; burst_len = 4'd2; memprepare = 1; mif.map_ready = 0; burst_start = 1;
        tick();
        burst_start = 0;
        // A load request while busy must be ignored.
        vma_we = 1; ob = 32'hDEADBEEF;
        for (int c = 0; c < 5; c++) begin
            $display("stall %0d: vma=%h mapi=%h valid=%b", c, vma, mif.mapi, mif.map_valid);
            n_cmp++;
            if (vma !== 32'h00012320 || mif.mapi !== 16'h0123 || mif.map_valid !== 1'b1) begin
                n_err++;
                $display("FAIL bp_hold: got vma=%h mapi=%h valid=%b expected vma=00012320 mapi=0123 valid=1", vma, mif.mapi, mif.map_valid);
            end
            tick();
            vma_we = 0;
        end
        mif.map_ready = 1;
        tick();
        mif.map_ready = 0;
        n_cmp++; if (mif.map_valid !== 1'b0) begin n_err++; $display("FAIL bp_issue_valid: got %b expected 0", mif.map_valid); end
        tick();
        $display("bp word 1: vma=%h mapi=%h valid=%b", vma, mif.mapi, mif.map_valid);
        n_cmp++; if (vma !== 32'h00012321) begin n_err++; $display("FAIL bp_vma2: got %h expected %h", vma, 32'h00012321); end
        n_cmp++; if (mif.map_valid !== 1'b1) begin n_err++; $display("FAIL bp_valid2: got %b expected 1", mif.map_valid); end
        mif.map_ready = 1;
        tick();
        mif.map_ready = 0;
        n_cmp++; if (burst_done !== 1'b1) begin n_err++; $display("FAIL bp_done: got %b expected 1", burst_done); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL bp_busy: got %b expected 0", busy); end
        tick();
        n_cmp++; if (burst_done !== 1'b0) begin n_err++; $display("FAIL bp_done_pulse: got %b expected 0", burst_done); end
    endtask

    task automatic test_wrap();
        int gap = 0;
        vmasel = 2'd1; ob = 32'hFFFFFFFF; burst_len = 4'd2; memprepare = 1; mif.map_ready = 1; burst_start = 1;
        tick();
        burst_start = 0;
        n_cmp++; if (mif.mapi !== 16'hFFFF) begin n_err++; $display("FAIL wrap_mapi0: got %h expected FFFF", mif.mapi); end
        tick();
        tick();
        $display("wrap word 1: vma=%h mapi=%h valid=%b pc=%b", vma, mif.mapi, mif.map_valid, page_cross);
        n_cmp++; if (vma !== 32'h0) begin n_err++; $display("FAIL wrap_vma: got %h expected 00000000", vma); end
        n_cmp++; if (mif.map_valid !== !PC_EN) begin n_err++; $display("FAIL wrap_valid: got %b expected %b", mif.map_valid, !PC_EN); end
        n_cmp++; if (page_cross !== PC_EN) begin n_err++; $display("FAIL wrap_pc: got %b expected %b", page_cross, PC_EN); end
        while (!mif.map_valid && gap < 4) begin
            tick();
            gap++;
        end
        n_cmp++; if (gap !== int'(PC_EN)) begin n_err++; $display("FAIL wrap_gap: got %0d expected %0d", gap, int'(PC_EN)); end
        n_cmp++; if (page_cross !== PC_EN) begin n_err++; $display("FAIL wrap_pc_hold: got %b expected %b", page_cross, PC_EN); end
        n_cmp++; if (mif.mapi !== 16'h0000) begin n_err++; $display("FAIL wrap_mapi1: got %h expected 0000", mif.mapi); end
        tick();
        mif.map_ready = 0;
        n_cmp++; if (burst_done !== 1'b1) begin n_err++; $display("FAIL wrap_done: got %b expected 1", burst_done); end
        n_cmp++; if (page_cross !== 1'b0) begin n_err++; $display("FAIL wrap_pc_clear: got %b expected 0", page_cross); end
    endtask

    task automatic test_reset_mid();
        vmasel = 2'd1; ob = 32'h40; burst_len = 4'd3; memprepare = 1; mif.map_ready = 0; burst_start = 1;
        tick();
        burst_start = 0;
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL rm_busy_pre: got %b expected 1", busy); end
        #2 reset_n = 1'b0;
        #1;
        $display("mid reset: vma=%h valid=%b busy=%b", vma, mif.map_valid, busy);
        n_cmp++; if (vma !== 32'h0) begin n_err++; $display("FAIL rm_vma: got %h expected 00000000", vma); end
        n_cmp++; if (mif.map_valid !== 1'b0) begin n_err++; $display("FAIL rm_valid: got %b expected 0", mif.map_valid); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rm_busy: got %b expected 0", busy); end
        for (int c = 0; c < 2; c++) begin
            tick();
            n_cmp++; if (burst_done !== 1'b0) begin n_err++; $display("FAIL rm_no_done: got %b expected 0", burst_done); end
        end
        reset_n = 1'b1;
        tick();
        vmasel = 2'd0; lc = 26'h0000808; memprepare = 1; vma_we = 1;
        tick();
        vma_we = 0;
        $display("post-reset load: vma=%h mapi=%h valid=%b", vma, mif.mapi, mif.map_valid);
        n_cmp++; if (vma !== 32'h202) begin n_err++; $display("FAIL rm_reload_vma: got %h expected 00000202", vma); end
        n_cmp++; if (mif.mapi !== 16'h0002) begin n_err++; $display("FAIL rm_reload_mapi: got %h expected 0002", mif.mapi); end
        n_cmp++; if (mif.map_valid !== 1'b1) begin n_err++; $display("FAIL rm_reload_valid: got %b expected 1", mif.map_valid); end
        mif.map_ready = 1;
        tick();
        mif.map_ready = 0;
        n_cmp++; if (burst_done !== 1'b0) begin n_err++; $display("FAIL rm_reload_done: got %b expected 0", burst_done); end
    endtask

    initial begin
        test_reset();
        test_lc_load();
        test_md_map();
        test_burst3();
        test_backpressure();
        test_wrap();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got still running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/vmas_seq.md
Name: vmas_seq

Overview:
- Parametrised next-generation VMA input selector with a registered VMA and a sequential-access (burst) engine.
- Selects the VMA source from four inputs: OB, LC, MD, or the incremented VMA.
- Holds the VMA in a register and presents the map-input field to the map stage over a valid/ready handshake.
- Sits between the M/A-bus result path and the L1/L2 map; lets microcode issue multi-word sequential memory references without reloading VMA per word.

Parameters:
- VW, 32, VMA/OB/MD width in bits.
- LCW, 26, location-counter width; byte address, word address is lc[LCW-1:2].
- MAPI_LO, 8, low bit of map-input field.
- MAPI_HI, 23, high bit of map-input field.
- CNTW, 4, burst counter width; max burst 2**CNTW-1 words.
- STRIDE, 1, word increment per burst step.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- ob  in  VW  output bus.
- md  in  VW  memory data.
- lc  in  LCW  location counter.
- vmasel  in  2  source: 0=LC, 1=OB, 2=MD, 3=VMA+STRIDE.
- vma_we  in  1  single load of VMA from selected source.
- burst_start  in  1  load VMA from source, then run burst.
- burst_len  in  CNTW  words in burst; 0 treated as 1.
- memprepare  in  1  map input from VMA when 1, from MD when 0.
- map_ready  in  1  map stage accepts mapi.
- vma  out  VW  VMA register.
- mapi  out  MAPI_HI-MAPI_LO+1  registered map input.
- map_valid  out  1  mapi valid.
- busy  out  1  burst in progress.
- burst_done  out  1  one-cycle pulse on final accepted word.
- page_cross  out  1  optional; see Optional Feature.

Behaviour:
- Reset (async, reset_n=0): vma=0, mapi=0, map_valid=0, busy=0, burst_done=0, page_cross=0; FSM to IDLE; counter=0.
- Source width rule:
  - LC = zero-extended {lc[LCW-1:2]} to VW.
  - VMA+STRIDE wraps modulo 2**VW.
- FSM states: IDLE, ISSUE, WAIT.
- IDLE:
  - vma_we=1: vma<=source next cycle. mapi<= (memprepare ? source : md) field. map_valid<=1. Go to WAIT with counter=0.
  - burst_start=1: same load; counter<=max(burst_len,1)-1; busy<=1; go to WAIT.
  - Both asserted: burst_start wins.
- WAIT:
  - Hold mapi/map_valid until map_ready=1.
  - On handshake, counter==0: map_valid<=0; burst_done pulses if busy; busy<=0; go to IDLE.
  - On handshake, counter>0: go to ISSUE.
- ISSUE (one cycle):
  - vma<=vma+STRIDE.
  - mapi<=new vma field.
  - map_valid<=1; counter--; go to WAIT.
- Latency:
  - Load-to-map_valid: 1 cycle.
  - Per-word burst throughput: 2 cycles minimum.
- vma_we or burst_start while not IDLE: ignored; no queueing.
- map_ready without map_valid: no effect.
- map_valid stays asserted, with mapi stable, until accepted.
- Reset mid-burst aborts immediately; no burst_done.

Optional Feature:
- Macro: VMAS_PAGE_CROSS_EN.
- With macro:
  - In ISSUE, if the increment changes any vma bit at or above MAPI_LO, page_cross<=1 for the WAIT period of that word.
  - The new mapi is held with map_valid=0 for one extra cycle, so the map RAM can reload before re-presentation.
- Without macro: page_cross tied 0; no extra cycle.

Decomposition:
- Shared package vmas_pkg:
  - vmasel encodings VMASEL_LC/OB/MD/INC.
  - FSM state typedef.
  - Default width constants.
- One sub-module, vmas_src_mux: purely combinational four-way source select plus LC shift and increment.
- FSM and registers live in the top.

Test Plan:
- Single LC load: vmasel=0, lc=26'h0000404, vma_we, memprepare=1 -> next cycle vma=32'h101, mapi=0x0001, map_valid=1; map_ready -> map_valid=0, no burst_done.
- MD map input: vmasel=1, ob=32'h00ABCD00, md=32'h00123400, memprepare=0, vma_we -> vma=32'h00ABCD00, mapi=0x1234.
- Burst of 3 from OB=32'h10, map_ready tied 1:
  - vma sequence 0x10, 0x11, 0x12 on successive valid words.
  - burst_done pulses once on the 0x12 handshake; busy falls the same edge.
- Backpressure: burst_len=2, map_ready=0 for 5 cycles -> mapi/vma stable, map_valid held; then ready -> advances to second word.
- Wrap and page cross: start vma=32'hFFFFFFFF, burst_len=2 -> second vma=0; with VMAS_PAGE_CROSS_EN page_cross=1 and one extra idle cycle before map_valid.
- Reset mid-burst: reset_n low during WAIT -> all outputs 0 asynchronously, no burst_done; a later vma_we works normally.
